// File: rtl/rv32v_ex_sequencer_if.sv
// Decode/hazard/lane handshake bundle for the rv32v execute-stage element sequencer.
// master drives decode and hazard inputs; slave is the sequencer side.
interface rv32v_ex_sequencer_if #(
    parameter int unsigned LANES = 2,
    parameter int unsigned VL_W  = 8
);
    logic              dec_valid;
    logic [VL_W-1:0]   dec_vl;
    logic [VL_W-1:0]   dec_vstart;
    logic              dec_ready;
    logic              stall_ex;
    logic              flush_ex;
    logic              busy_ex;
    logic              ex_valid;
    logic [VL_W-1:0]   ex_elem_idx;
    logic [LANES-1:0]  ex_lane_mask;
    logic              ex_last;
    logic              ex_done;

    modport master (
        output dec_valid, dec_vl, dec_vstart, stall_ex, flush_ex,
        input  dec_ready, busy_ex, ex_valid, ex_elem_idx, ex_lane_mask, ex_last, ex_done
    );

    modport slave (
        input  dec_valid, dec_vl, dec_vstart, stall_ex, flush_ex,
        output dec_ready, busy_ex, ex_valid, ex_elem_idx, ex_lane_mask, ex_last, ex_done
    );
endinterface

// File: rtl/rv32v_ex_sequencer.sv
// Execute-stage element sequencer: walks the active elements of one vector instruction,
// LANES per cycle. Optional chunk counter enabled by defining RV32V_EX_SEQ_PERF_EN.
module rv32v_ex_sequencer #(
    parameter int unsigned LANES = 2,
    parameter int unsigned VL_W  = 8
) (
    input  logic                        CLK,
    input  logic                        RST,
    rv32v_ex_sequencer_if.slave         bus
`ifdef RV32V_EX_SEQ_PERF_EN
    ,
    output logic [31:0]                 perf_chunks
`endif
);

    typedef logic [VL_W-1:0] idx_t;
    typedef logic [VL_W:0]   ext_t;

    typedef enum logic {StIdle, StRun} state_e;

    state_e state_q, state_d;
    idx_t   idx_q, idx_d;
    idx_t   vl_q, vl_d;
    logic   done_q, done_d;

    logic             run;
    logic             last;
    logic [LANES-1:0] lane_mask;
    logic             accept;
    logic             zero_elem;
    logic             advance;
    ext_t             idx_ext;
    ext_t             vl_ext;

    assign run       = (state_q == StRun);
    assign idx_ext   = {1'b0, idx_q};
    assign vl_ext    = {1'b0, vl_q};
    assign zero_elem = (bus.dec_vstart >= bus.dec_vl);

    // One extra bit keeps idx+i and idx+LANES from wrapping near the top of the range.
    always_comb begin
        lane_mask = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_mask[i] = (idx_ext + ext_t'(i)) < vl_ext;
        end
    end

    assign last = (idx_ext + ext_t'(LANES)) >= vl_ext;

    assign bus.ex_valid     = run;
    assign bus.ex_elem_idx  = idx_q;
    assign bus.ex_lane_mask = run ? lane_mask : '0;
    assign bus.ex_last      = run & last;
    assign bus.busy_ex      = run & ~last;
    assign bus.ex_done      = done_q;
    assign bus.dec_ready    = ~run | (last & ~bus.stall_ex);

    assign accept  = bus.dec_valid & bus.dec_ready & ~bus.flush_ex;
    assign advance = run & ~bus.stall_ex & ~bus.flush_ex;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        vl_d    = vl_q;
        done_d  = 1'b0;

        if (bus.flush_ex) begin
            state_d = StIdle;
        end else begin
            if (advance) begin
                if (last) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + idx_t'(LANES);
                end
            end
            // Acceptance in RUN only happens on the final unstalled chunk, so it overrides
            // the return to IDLE while leaving done_d set for the retiring instruction.
            if (accept) begin
                if (zero_elem) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    state_d = StRun;
                    idx_d   = bus.dec_vstart;
                    vl_d    = bus.dec_vl;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            idx_q   <= '0;
            vl_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            vl_q    <= vl_d;
            done_q  <= done_d;
        end
    end

`ifdef RV32V_EX_SEQ_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            perf_q <= '0;
        end else if (advance && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_chunks = perf_q;
`endif

endmodule

// File: tb/tb_rv32v_ex_sequencer.sv
// Directed self-checking bench for rv32v_ex_sequencer with LANES=2, VL_W=8.
module tb_rv32v_ex_sequencer;

    localparam int unsigned LANES = 2;
    localparam int unsigned VL_W  = 8;

    logic CLK = 1'b0;
    logic RST = 1'b1;
`ifdef RV32V_EX_SEQ_PERF_EN
    logic [31:0] perf_chunks;
`endif

    int n_vec = 0;
    int n_err = 0;

    rv32v_ex_sequencer_if #(.LANES(LANES), .VL_W(VL_W)) bus ();

    rv32v_ex_sequencer #(.LANES(LANES), .VL_W(VL_W)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .bus         (bus)
`ifdef RV32V_EX_SEQ_PERF_EN
        ,
        .perf_chunks (perf_chunks)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after inputs settle, well clear of the posedge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [VL_W-1:0] idx,
                              input logic [LANES-1:0] mask, input logic last,
                              input logic busy, input logic done, input logic ready);
        #1;
        check({tag, ".valid"}, 32'(bus.ex_valid), 32'(v));
        if (v) check({tag, ".idx"}, 32'(bus.ex_elem_idx), 32'(idx));
        check({tag, ".mask"}, 32'(bus.ex_lane_mask), 32'(mask));
        check({tag, ".last"}, 32'(bus.ex_last), 32'(last));
        check({tag, ".busy"}, 32'(bus.busy_ex), 32'(busy));
        check({tag, ".done"}, 32'(bus.ex_done), 32'(done));
        check({tag, ".ready"}, 32'(bus.dec_ready), 32'(ready));
    endtask

    task automatic issue(input logic [VL_W-1:0] vl, input logic [VL_W-1:0] vstart);
        bus.dec_valid  = 1'b1;
        bus.dec_vl     = vl;
        bus.dec_vstart = vstart;
    endtask

    initial begin
        bus.dec_valid  = 1'b0;
        bus.dec_vl     = '0;
        bus.dec_vstart = '0;
        bus.stall_ex   = 1'b0;
        bus.flush_ex   = 1'b0;
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        expect_out("rst", 1'b0, 8'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        check("rst.idx", 32'(bus.ex_elem_idx), 32'd0);

        // vl=5, vstart=0: chunks 0/2/4, partial mask on the last.
        issue(8'd5, 8'd0);
        tick();
        bus.dec_valid = 1'b0;
        expect_out("vl5.c0", 1'b1, 8'd0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("vl5.c1", 1'b1, 8'd2, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("vl5.c2", 1'b1, 8'd4, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        expect_out("vl5.done", 1'b0, 8'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        expect_out("vl5.quiet", 1'b0, 8'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);

        // Zero-element: vstart == vl.
        issue(8'd4, 8'd4);
        tick();
        bus.dec_valid = 1'b0;
        expect_out("zero.done", 1'b0, 8'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        expect_out("zero.quiet", 1'b0, 8'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);

        // vl=6 with a 3-cycle stall at idx 2.
        issue(8'd6, 8'd0);
        tick();
        bus.dec_valid = 1'b0;
        expect_out("stl.c0", 1'b1, 8'd0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        bus.stall_ex = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_out($sformatf("stl.hold%0d", i), 1'b1, 8'd2, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
            tick();
        end
        bus.stall_ex = 1'b0;
        expect_out("stl.rel", 1'b1, 8'd2, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("stl.c2", 1'b1, 8'd4, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        expect_out("stl.done", 1'b0, 8'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);

        // Back-to-back: vl=2 then vl=3 with dec_valid held.
        issue(8'd2, 8'd0);
        tick();
        issue(8'd3, 8'd0);
        expect_out("b2b.a0", 1'b1, 8'd0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        bus.dec_valid = 1'b0;
        expect_out("b2b.b0", 1'b1, 8'd0, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        expect_out("b2b.b1", 1'b1, 8'd2, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        expect_out("b2b.done", 1'b0, 8'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);

        // Flush at idx 2 of vl=8 while decode offers another instruction.
        issue(8'd8, 8'd0);
        tick();
        bus.dec_valid = 1'b0;
        tick();
        issue(8'd4, 8'd0);
        bus.flush_ex = 1'b1;
        expect_out("fl.c1", 1'b1, 8'd2, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        bus.flush_ex  = 1'b0;
        bus.dec_valid = 1'b0;
        expect_out("fl.idle", 1'b0, 8'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        expect_out("fl.nodone", 1'b0, 8'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);

        // Top of range: vl=255, vstart=254 gives one chunk, no wrap.
        issue(8'd255, 8'd254);
        tick();
        bus.dec_valid = 1'b0;
        expect_out("max.c0", 1'b1, 8'd254, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        expect_out("max.done", 1'b0, 8'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);

        // Reset mid-RUN abandons the instruction.
        issue(8'd8, 8'd0);
        tick();
        bus.dec_valid = 1'b0;
        tick();
        RST = 1'b1;
        expect_out("mrst.pre", 1'b1, 8'd2, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        RST = 1'b0;
        expect_out("mrst.post", 1'b0, 8'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        check("mrst.idx", 32'(bus.ex_elem_idx), 32'd0);
        tick();
        expect_out("mrst.nodone", 1'b0, 8'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rv32v_ex_sequencer.md
Name: rv32v_ex_sequencer

Overview:
- Execute-stage element sequencer for the rv32v pipeline.
- Accepts one decoded vector instruction at a time and steps through its active elements, LANES elements per cycle.
- Emits per-chunk element index, lane mask and last flag to the execute lanes.
- Produces busy_ex for the vector hazard unit, and consumes that unit's stall_ex and flush_ex.

Parameters:
- LANES, 2, elements processed per cycle; power of two, 1..8.
- VL_W, 8, width of vl, vstart and element-index fields.

Ports:
- CLK  input  1  clock.
- RST  input  1  synchronous active-high reset.
- dec_valid  input  1  decode presents an instruction.
- dec_vl  input  VL_W  vector length of the instruction.
- dec_vstart  input  VL_W  first element to process.
- dec_ready  output  1  sequencer accepts an instruction this cycle.
- stall_ex  input  1  hazard-unit stall for execute.
- flush_ex  input  1  hazard-unit flush for execute.
- busy_ex  output  1  multi-cycle instruction in progress; this signal goes to the hazard unit.
- ex_valid  output  1  a chunk is presented to the lanes.
- ex_elem_idx  output  VL_W  element index of lane 0 in the current chunk.
- ex_lane_mask  output  LANES  per-lane active bit.
- ex_last  output  1  current chunk is the final one of the instruction.
- ex_done  output  1  one-cycle pulse after the final chunk retires, or after a zero-element instruction.

Behaviour:
- States:
  - IDLE, RUN.
  - Registers: state, idx (VL_W), vl_q (VL_W), done_q.
- Reset (RST=1 at posedge):
  - state=IDLE, idx=0, vl_q=0, done_q=0.
  - Outputs therefore reset to ex_valid=0, busy_ex=0, ex_last=0, ex_lane_mask=0, ex_elem_idx=0, ex_done=0, dec_ready=1.
  - Reset mid-RUN abandons the instruction; no ex_done is produced.
- Accept condition: dec_valid & dec_ready & !flush_ex.
  - If dec_vstart >= dec_vl: the instruction is zero-element. Go to or remain in IDLE, and ex_done=1 on the next cycle.
  - Otherwise: idx<=dec_vstart, vl_q<=dec_vl, state<=RUN.
  - Latency: the first chunk is visible the cycle after acceptance.
- Output decode:
  - RUN: ex_valid=1 and ex_elem_idx=idx.
  - Lane mask: ex_lane_mask[i] = (idx+i < vl_q), computed at VL_W+1 bits so there is no wrap.
  - Last flag: ex_last = (idx+LANES >= vl_q), computed at VL_W+1 bits.
  - IDLE: ex_valid, mask and last are all 0.
- Advance, in RUN with !stall_ex and !flush_ex:
  - Not last: idx<=idx+LANES.
  - Last: state<=IDLE and done_q<=1, unless a new instruction is accepted in the same cycle, in which case reload and stay in RUN. done_q is still set.
- Stall: in RUN with stall_ex=1 and flush_ex=0, all registers hold and outputs are stable.
- Flush (flush_ex=1):
  - Has priority over stall and accept.
  - Next state is IDLE, done_q<=0 and no acceptance.
  - ex_done is never asserted for a flushed instruction.
- busy_ex = (state==RUN) & !ex_last. This is combinational from registers.
- dec_ready = (state==IDLE) | (state==RUN & ex_last & !stall_ex). This allows back-to-back issue with zero bubbles.
- ex_done = done_q, which is cleared every cycle unless set as above.
- Boundary conditions:
  - vl_q equal to the VL_W maximum: no overflow, because all comparisons are at VL_W+1 bits.
  - vl not a multiple of LANES: the final chunk has a partial mask.
  - dec_vstart nonzero: elements below vstart are never presented.

Optional Feature:
- Macro: RV32V_EX_SEQ_PERF_EN.
- When defined:
  - Adds output perf_chunks (32 bits). It increments once per retired chunk (RUN & !stall_ex & !flush_ex) and saturates at 0xFFFFFFFF.
  - Reset value is 0. It is not cleared by flush.
- When undefined, the port and the counter are absent and behaviour is otherwise identical.

Test Plan:
- LANES=2, vl=5, vstart=0, no stall:
  - Chunks are idx 0/2/4 with masks 11/11/01.
  - ex_last only on idx 4. busy_ex is 1 on the first two chunks and 0 on the third.
  - ex_done pulses one cycle after idx 4.
- vl=4, vstart=4 (zero-element): ex_valid stays 0, ex_done=1 on the next cycle, dec_ready stays 1.
- vl=6 with stall_ex held for 3 cycles at idx 2: idx 2 and mask 11 are held for the 3 cycles, then the sequence resumes at idx 4.
- Two back-to-back instructions (vl=2, then vl=3), dec_valid continuous:
  - Second instruction is accepted on the last chunk of the first.
  - Chunks are idx 0, then idx 0 (mask 11), then idx 2 (mask 01), with no bubble.
- flush_ex at idx 2 of vl=8, with dec_valid also high: next cycle is IDLE, no ex_done, and the instruction is not accepted that cycle.
- VL_W=8, vl=255, vstart=254: a single chunk at idx 254 with mask 01 and ex_last=1, with no wrap. RST asserted mid-RUN returns all outputs to their reset values on the next cycle.
